// File: rtl/alu_req_arbiter_if.sv
// Bundle of request, response and ALU-side signals for the two-requester ALU arbiter.
// The arbiter takes the slave view; requesters and the external ALU take the master view.
interface alu_req_arbiter_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned FW = 4
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [2*W-1:0]  req_cin;
  logic [2*FW-1:0] req_f;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [W-1:0]    alu_cin;
  logic [FW-1:0]   alu_f;
  logic [W-1:0]    alu_d;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_f, rsp_ready, alu_d,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_cin, alu_f
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_f, rsp_ready, alu_d,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_cin, alu_f
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Registers the winner's operands, waits EXEC_CYCLES, captures D and returns it over valid/ready.
module alu_req_arbiter #(
  parameter int unsigned W           = 4,
  parameter int unsigned FW          = 4,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_req_arbiter_if.slave     bus,
  output logic                 busy
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            grant_id_q, grant_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [W-1:0]    alu_cin_q, alu_cin_d;
  logic [FW-1:0]   alu_f_q, alu_f_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;

  logic            win_valid;
  logic            winner;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;

  always_comb begin
    win_valid = 1'b0;
    winner    = rr_ptr_q;
    if (bus.req_valid[rr_ptr_q]) begin
      win_valid = 1'b1;
      winner    = rr_ptr_q;
    end else if (bus.req_valid[~rr_ptr_q]) begin
      win_valid = 1'b1;
      winner    = ~rr_ptr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    alu_f_d    = alu_f_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;

    case (state_q)
      StIdle: begin
        // Gated by rst_n so that every output reads zero while reset is held.
        if (rst_n && win_valid) begin
          req_ready[winner] = 1'b1;
          alu_a_d    = winner ? bus.req_a[2*W-1:W]     : bus.req_a[W-1:0];
          alu_b_d    = winner ? bus.req_b[2*W-1:W]     : bus.req_b[W-1:0];
          alu_cin_d  = winner ? bus.req_cin[2*W-1:W]   : bus.req_cin[W-1:0];
          alu_f_d    = winner ? bus.req_f[2*FW-1:FW]   : bus.req_f[FW-1:0];
          grant_id_d = winner;
          rr_ptr_d   = ~winner;
          cnt_d      = '0;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (cnt_q == CntLast) begin
          rsp_data_d = bus.alu_d;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (bus.rsp_ready[grant_id_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      grant_id_q <= 1'b0;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= '0;
      alu_f_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_f_q    <= alu_f_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_cin   = alu_cin_q;
  assign bus.alu_f     = alu_f_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: vector table for single ops plus sequences for
// fairness, backpressure, reset mid-operation and a three-cycle execute variant.
module tb_alu_req_arbiter;
  localparam int unsigned W  = 4;
  localparam int unsigned FW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy1;
  logic busy3;

  always #5 clk = ~clk;

  alu_req_arbiter_if #(.W(W), .FW(FW)) bus1 ();
  alu_req_arbiter_if #(.W(W), .FW(FW)) bus3 ();

  // Stub ALU: sum of the three operands, truncated to W bits.
  assign bus1.alu_d = bus1.alu_a + bus1.alu_b + bus1.alu_cin;
  assign bus3.alu_d = bus3.alu_a + bus3.alu_b + bus3.alu_cin;

  alu_req_arbiter #(.W(W), .FW(FW), .EXEC_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .busy  (busy1)
  );

  alu_req_arbiter #(.W(W), .FW(FW), .EXEC_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3),
    .busy  (busy3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one lane of bus1 with the given payload and the other lane with its complement.
  task automatic drive1(input logic lane, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] cin, input logic [3:0] f);
    bus1.req_a   = lane ? {a, ~a}     : {~a, a};
    bus1.req_b   = lane ? {b, ~b}     : {~b, b};
    bus1.req_cin = lane ? {cin, ~cin} : {~cin, cin};
    bus1.req_f   = lane ? {f, ~f}     : {~f, f};
  endtask

  typedef struct {
    logic       r;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] cin;
    logic [3:0] f;
    logic [3:0] d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 4'd3,  4'd4,  4'd1,  4'd2,  4'd8};
    vecs[1] = '{1'b1, 4'd9,  4'd8,  4'd0,  4'd5,  4'd1};
    vecs[2] = '{1'b0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd13};
    vecs[3] = '{1'b1, 4'd0,  4'd0,  4'd0,  4'd0,  4'd0};
    vecs[4] = '{1'b1, 4'd7,  4'd1,  4'd1,  4'd3,  4'd9};
    vecs[5] = '{1'b0, 4'd5,  4'd10, 4'd0,  4'd12, 4'd15};

    bus1.req_valid = 2'b11;
    bus1.rsp_ready = 2'b00;
    drive1(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    bus3.req_valid = 2'b00;
    bus3.rsp_ready = 2'b00;
    bus3.req_a = '0; bus3.req_b = '0; bus3.req_cin = '0; bus3.req_f = '0;

    // Reset state, with requests pending to show req_ready is held low.
    #1 rst_n = 1'b0;
    #2;
    chk("reset_req_ready", bus1.req_ready, 2'b00);
    chk("reset_rsp_valid", bus1.rsp_valid, 2'b00);
    chk("reset_busy",      busy1,          1'b0);
    chk("reset_alu_a",     bus1.alu_a,     4'd0);
    chk("reset_alu_f",     bus1.alu_f,     4'd0);
    chk("reset_rsp_data",  bus1.rsp_data,  4'd0);
    chk("reset_busy3",     busy3,          1'b0);

    @(negedge clk);
    bus1.req_valid = 2'b00;
    rst_n = 1'b1;

    // Table-driven single operations (one requester at a time).
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive1(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].f);
      bus1.req_valid = vecs[i].r ? 2'b10 : 2'b01;
      bus1.rsp_ready = 2'b11;
      #1;
      chk("tbl_req_ready", bus1.req_ready, vecs[i].r ? 2'b10 : 2'b01);
      chk("tbl_idle_busy", busy1, 1'b0);
      @(negedge clk);
      bus1.req_valid = 2'b00;
      drive1(vecs[i].r, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("tbl_alu_a",     bus1.alu_a,   vecs[i].a);
      chk("tbl_alu_b",     bus1.alu_b,   vecs[i].b);
      chk("tbl_alu_cin",   bus1.alu_cin, vecs[i].cin);
      chk("tbl_alu_f",     bus1.alu_f,   vecs[i].f);
      chk("tbl_exec_rdy",  bus1.req_ready, 2'b00);
      chk("tbl_exec_busy", busy1, 1'b1);
      chk("tbl_exec_rspv", bus1.rsp_valid, 2'b00);
      @(negedge clk);
      chk("tbl_rsp_valid", bus1.rsp_valid, vecs[i].r ? 2'b10 : 2'b01);
      chk("tbl_rsp_data",  bus1.rsp_data,  vecs[i].d);
      @(negedge clk);
      chk("tbl_done_rspv", bus1.rsp_valid, 2'b00);
      chk("tbl_done_busy", busy1, 1'b0);
    end

    // Fairness: both valid continuously from reset, grants alternate 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    bus1.req_valid = 2'b11;
    bus1.rsp_ready = 2'b11;
    bus1.req_a   = {4'd2, 4'd1};
    bus1.req_b   = {4'd3, 4'd1};
    bus1.req_cin = {4'd1, 4'd0};
    bus1.req_f   = {4'd7, 4'd6};
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fair_grant", bus1.req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("fair_exec_rdy", bus1.req_ready, 2'b00);
      chk("fair_alu_f", bus1.alu_f, (k % 2 == 1) ? 4'd7 : 4'd6);
      @(negedge clk);
      chk("fair_resp_rdy", bus1.req_ready, 2'b00);
      chk("fair_rsp_valid", bus1.rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("fair_rsp_data", bus1.rsp_data, (k % 2 == 1) ? 4'd6 : 4'd2);
      if (k == 3) bus1.req_valid = 2'b00;
      @(negedge clk);
    end

    // Backpressure: response to requester 0 held while requester 1 waits.
    drive1(1'b0, 4'd6, 4'd5, 4'd2, 4'd1);
    bus1.req_valid = 2'b01;
    bus1.rsp_ready = 2'b00;
    #1;
    chk("bp_grant0", bus1.req_ready, 2'b01);
    @(negedge clk);
    bus1.req_valid = 2'b10;
    drive1(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    bus1.rsp_ready = 2'b10;
    #1;
    chk("bp_exec_rdy", bus1.req_ready, 2'b00);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_hold_rspv", bus1.rsp_valid, 2'b01);
      chk("bp_hold_data", bus1.rsp_data, 4'd13);
      chk("bp_hold_rdy",  bus1.req_ready, 2'b00);
      @(negedge clk);
    end
    bus1.rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("bp_grant1", bus1.req_ready, 2'b10);
    chk("bp_rel_rspv", bus1.rsp_valid, 2'b00);
    bus1.rsp_ready = 2'b11;
    @(negedge clk);
    bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("bp_rsp1_valid", bus1.rsp_valid, 2'b10);
    chk("bp_rsp1_data",  bus1.rsp_data, 4'd6);
    @(negedge clk);

    // Reset during EXEC, then during RESP.
    drive1(1'b1, 4'd3, 4'd3, 4'd3, 4'd1);
    bus1.req_valid = 2'b10;
    bus1.rsp_ready = 2'b11;
    @(negedge clk);
    chk("rst_exec_busy", busy1, 1'b1);
    bus1.req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exec_alu_a", bus1.alu_a, 4'd0);
    chk("rst_exec_alu_f", bus1.alu_f, 4'd0);
    chk("rst_exec_busy0", busy1, 1'b0);
    chk("rst_exec_rdy",   bus1.req_ready, 2'b00);
    chk("rst_exec_rspv",  bus1.rsp_valid, 2'b00);
    drive1(1'b0, 4'd2, 4'd2, 4'd1, 4'd6);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_first_grant", bus1.req_ready, 2'b01);
    @(negedge clk);
    bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("rst_resp_valid", bus1.rsp_valid, 2'b01);
    chk("rst_resp_data",  bus1.rsp_data, 4'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_rspv", bus1.rsp_valid, 2'b00);
    chk("rst_resp_data0", bus1.rsp_data, 4'd0);
    chk("rst_resp_busy", busy1, 1'b0);
    chk("rst_resp_alu_b", bus1.alu_b, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("rst_no_rsp", bus1.rsp_valid, 2'b00);
      chk("rst_no_busy", busy1, 1'b0);
    end

    // EXEC_CYCLES=3 instance: response exactly three cycles after accept.
    bus3.req_a   = {4'd0, 4'd4};
    bus3.req_b   = {4'd0, 4'd5};
    bus3.req_cin = {4'd0, 4'd6};
    bus3.req_f   = {4'd0, 4'd9};
    bus3.req_valid = 2'b01;
    bus3.rsp_ready = 2'b01;
    #1;
    chk("x3_grant", bus3.req_ready, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus3.req_valid = 2'b00;
        bus3.req_a = '0; bus3.req_b = '0; bus3.req_cin = '0; bus3.req_f = '0;
      end
      chk("x3_wait_rspv", bus3.rsp_valid, 2'b00);
      chk("x3_alu_a",     bus3.alu_a,   4'd4);
      chk("x3_alu_b",     bus3.alu_b,   4'd5);
      chk("x3_alu_cin",   bus3.alu_cin, 4'd6);
      chk("x3_alu_f",     bus3.alu_f,   4'd9);
      chk("x3_busy",      busy3,        1'b1);
    end
    @(negedge clk);
    chk("x3_rsp_valid", bus3.rsp_valid, 2'b01);
    chk("x3_rsp_data",  bus3.rsp_data,  4'd15);
    @(negedge clk);
    chk("x3_done_busy", busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
